// File: rtl/zone_acc_writer_pkg.sv
// Shared types, default widths and the accumulate adder for zone_acc_writer.
// Build option: define ZONE_ACC_SAT_EN to make the adder saturate instead of wrap.
package zone_acc_pkg;

  localparam int ZACC_ADDR_W = 7;
  localparam int ZACC_PIX_W  = 8;
  localparam int ZACC_DATA_W = 60;

  typedef enum logic [2:0] {
    ZACC_IDLE  = 3'd0,
    ZACC_CLEAR = 3'd1,
    ZACC_ACCUM = 3'd2,
    ZACC_DRAIN = 3'd3,
    ZACC_DONE  = 3'd4
  } zacc_state_t;

  // Adds a zero-extended green sample to a running zone sum.
  function automatic logic [ZACC_DATA_W-1:0] zacc_add(
    input logic [ZACC_DATA_W-1:0] base,
    input logic [ZACC_PIX_W-1:0]  g
  );
`ifdef ZONE_ACC_SAT_EN
    logic [ZACC_DATA_W:0] full;
    full = {1'b0, base} + {{(ZACC_DATA_W+1-ZACC_PIX_W){1'b0}}, g};
    return full[ZACC_DATA_W] ? {ZACC_DATA_W{1'b1}} : full[ZACC_DATA_W-1:0];
`else
    return base + {{(ZACC_DATA_W-ZACC_PIX_W){1'b0}}, g};
`endif
  endfunction

endpackage

// File: rtl/zone_acc_writer_if.sv
// Zone-tagged pixel stream handshake between the zone mapper and zone_acc_writer.
interface zone_acc_writer_if
  import zone_acc_pkg::*;
#(
  parameter int ADDR_W = ZACC_ADDR_W,
  parameter int PIX_W  = ZACC_PIX_W
) ();

  logic              pix_valid;
  logic              pix_ready;
  logic [ADDR_W-1:0] pix_zone;
  logic [PIX_W-1:0]  pix_g;

  modport master (output pix_valid, output pix_zone, output pix_g, input pix_ready);
  modport slave  (input pix_valid, input pix_zone, input pix_g, output pix_ready);

endinterface

// File: rtl/zone_acc_writer.sv
// Per-zone green accumulator: clears G_re at frame start, then pipelined read-modify-write.
// Build option: ZONE_ACC_SAT_EN selects a saturating adder (see zone_acc_pkg).
module zone_acc_writer
  import zone_acc_pkg::*;
#(
  parameter int ADDR_W = ZACC_ADDR_W,
  parameter int PIX_W  = ZACC_PIX_W,
  parameter int DATA_W = ZACC_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              frame_end,
  zone_acc_writer_if.slave  pix,
  output logic              frame_done,
  output logic              busy,
  input  logic [ADDR_W-1:0] ext_rd_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data
);

  zacc_state_t       state_q;
  logic [ADDR_W-1:0] clr_cnt_q;
  logic              frame_done_q;

  logic              vld_p1;
  logic [ADDR_W-1:0] zone_p1;
  logic [PIX_W-1:0]  g_p1;

  logic              vld_p2;
  logic [ADDR_W-1:0] zone_p2;
  logic [DATA_W-1:0] sum_p2;

  logic              in_clear;
  logic              host_owns_rd;
  logic              accept;
  logic [DATA_W-1:0] base_p1;
  logic [DATA_W-1:0] sum_nxt_p1;

  assign in_clear      = (state_q == ZACC_CLEAR);
  assign host_owns_rd  = (state_q == ZACC_IDLE) || (state_q == ZACC_DONE);
  assign pix.pix_ready = (state_q == ZACC_ACCUM);
  assign accept        = pix.pix_valid && pix.pix_ready;
  assign busy          = (state_q == ZACC_CLEAR) || (state_q == ZACC_ACCUM) ||
                         (state_q == ZACC_DRAIN);
  assign frame_done    = frame_done_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ZACC_IDLE;
      clr_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        ZACC_IDLE, ZACC_DONE: begin
          if (frame_start) begin
            state_q   <= ZACC_CLEAR;
            clr_cnt_q <= '0;
          end
        end
        ZACC_CLEAR: begin
          if (frame_start) begin
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
            if (clr_cnt_q == {ADDR_W{1'b1}}) state_q <= ZACC_ACCUM;
          end
        end
        ZACC_ACCUM: begin
          if (frame_start) begin
            state_q   <= ZACC_CLEAR;
            clr_cnt_q <= '0;
          end else if (frame_end) begin
            state_q <= ZACC_DRAIN;
          end
        end
        ZACC_DRAIN: begin
          if (frame_start) begin
            state_q   <= ZACC_CLEAR;
            clr_cnt_q <= '0;
          end else if (!vld_p1 && !vld_p2) begin
            state_q      <= ZACC_DONE;
            frame_done_q <= 1'b1;
          end
        end
        default: state_q <= ZACC_IDLE;
      endcase
    end
  end

  // A frame_start flushes both stages, so writes still in flight never reach the RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= accept && !frame_start;
      vld_p2 <= vld_p1 && !frame_start;
    end
  end

  // ---- stage p1: accepted pixel, RAM read address ----
  always_ff @(posedge clk) begin
    if (accept) begin
      zone_p1 <= pix.pix_zone;
      g_p1    <= pix.pix_g;
    end
  end

  // The RAM has not yet seen the sum sitting in p2, so forward it on a zone hit.
  assign base_p1    = (vld_p2 && (zone_p2 == zone_p1)) ? sum_p2 : ram_rd_data;
  assign sum_nxt_p1 = zacc_add(base_p1, g_p1);

  // ---- stage p2: updated sum, RAM write ----
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      zone_p2 <= zone_p1;
      sum_p2  <= sum_nxt_p1;
    end
  end

  always_comb begin
    ram_wr_en   = 1'b0;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    if (in_clear) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = clr_cnt_q;
    end else if (vld_p2) begin
      ram_wr_en   = !frame_start;
      ram_wr_addr = zone_p2;
      ram_wr_data = sum_p2;
    end
  end

  assign ram_rd_addr = host_owns_rd ? ext_rd_addr : zone_p1;

endmodule

// File: tb/tb_zone_acc_writer.sv
// Self-checking bench for zone_acc_writer with a behavioural G_re RAM and per-zone sum model.
module tb_zone_acc_writer;
  import zone_acc_pkg::*;

  localparam int ADDR_W = 7;
  localparam int PIX_W  = 8;
  localparam int DATA_W = 60;
  localparam int ZONES  = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] MAX_SUM = {DATA_W{1'b1}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, frame_start, frame_end, frame_done, busy;
  logic [ADDR_W-1:0] ext_rd_addr, ram_wr_addr, ram_rd_addr;
  logic [DATA_W-1:0] ram_wr_data, ram_rd_data;
  logic              ram_wr_en;

  logic              bd_en;
  logic [ADDR_W-1:0] bd_addr;
  logic [DATA_W-1:0] bd_data;

  zone_acc_writer_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) pix ();

  zone_acc_writer #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .pix         (pix),
    .frame_done  (frame_done),
    .busy        (busy),
    .ext_rd_addr (ext_rd_addr),
    .ram_wr_data (ram_wr_data),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_en   (ram_wr_en),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data)
  );

  // G_re: 128 x 60 SDPRAM, synchronous write, asynchronous read; bd_* is a backdoor load.
  logic [DATA_W-1:0] g_re [ZONES];
  always @(posedge clk) begin
    if (bd_en) g_re[bd_addr] <= bd_data;
    else if (ram_wr_en) g_re[ram_wr_addr] <= ram_wr_data;
  end
  assign ram_rd_data = g_re[ram_rd_addr];

  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] model [ZONES];

  typedef struct packed {
    logic [2:0]             n;
    logic [3:0][ADDR_W-1:0] zone;
    logic [3:0][PIX_W-1:0]  g;
    logic [2:0][ADDR_W-1:0] cz;
    logic [2:0][DATA_W-1:0] ce;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  function automatic logic [DATA_W-1:0] ref_add(input logic [DATA_W-1:0] a, input logic [PIX_W-1:0] g);
    logic [DATA_W:0] s;
    s = {1'b0, a} + (DATA_W+1)'(g);
`ifdef ZONE_ACC_SAT_EN
    if (s > {1'b0, MAX_SUM}) return MAX_SUM;
`endif
    return s[DATA_W-1:0];
  endfunction

  task automatic set_vec(input int i, input int n,
                         input logic [ADDR_W-1:0] z0, z1, z2, z3,
                         input logic [PIX_W-1:0] g0, g1, g2, g3,
                         input logic [ADDR_W-1:0] c0, c1, c2,
                         input logic [DATA_W-1:0] e0, e1, e2);
    vecs[i].n = 3'(n);
    vecs[i].zone[0] = z0; vecs[i].zone[1] = z1; vecs[i].zone[2] = z2; vecs[i].zone[3] = z3;
    vecs[i].g[0] = g0; vecs[i].g[1] = g1; vecs[i].g[2] = g2; vecs[i].g[3] = g3;
    vecs[i].cz[0] = c0; vecs[i].cz[1] = c1; vecs[i].cz[2] = c2;
    vecs[i].ce[0] = e0; vecs[i].ce[1] = e1; vecs[i].ce[2] = e2;
  endtask

  // Pulse frame_start (optionally with frame_end) and watch the full clear sweep.
  task automatic start_and_clear(input string name, input bit with_end);
    int bad = 0;
    frame_start = 1'b1;
    frame_end   = with_end;
    @(negedge clk);
    frame_start = 1'b0;
    frame_end   = 1'b0;
    for (int i = 0; i < ZONES; i++) begin
      if (!(ram_wr_en === 1'b1 && ram_wr_addr === ADDR_W'(i) &&
            ram_wr_data === '0 && pix.pix_ready === 1'b0 && busy === 1'b1)) bad++;
      @(negedge clk);
    end
    check({name, "_clear_sweep_bad_cycles"}, 64'(bad), 64'd0);
    check({name, "_ready_after_clear"}, 64'(pix.pix_ready), 64'd1);
    for (int z = 0; z < ZONES; z++) model[z] = '0;
  endtask

  task automatic send(input logic [ADDR_W-1:0] z, input logic [PIX_W-1:0] g, input bit last);
    pix.pix_valid = 1'b1;
    pix.pix_zone  = z;
    pix.pix_g     = g;
    frame_end     = last;
    model[z]      = ref_add(model[z], g);
    @(negedge clk);
    pix.pix_valid = 1'b0;
    frame_end     = 1'b0;
  endtask

  // Called on the negedge after frame_end was sampled (or later).
  task automatic finish_frame(input string name);
    int pulses = 0;
    int first  = 0;
    for (int k = 1; k <= 8; k++) begin
      if (frame_done === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
      @(negedge clk);
    end
    check({name, "_done_pulses"}, 64'(pulses), 64'd1);
    check({name, "_done_within_3"}, 64'(first >= 1 && first <= 4), 64'd1);
    check({name, "_busy_after_done"}, 64'(busy), 64'd0);
  endtask

  task automatic readback(input logic [ADDR_W-1:0] z, output logic [DATA_W-1:0] d);
    ext_rd_addr = z;
    #1;
    d = ram_rd_data;
  endtask

  task automatic compare_all(input string name);
    int mism = 0;
    logic [DATA_W-1:0] d;
    for (int z = 0; z < ZONES; z++) begin
      readback(ADDR_W'(z), d);
      if (d !== model[z]) begin
        if (mism == 0) $display("note %s: zone %0d holds %0d, model %0d", name, z, d, model[z]);
        mism++;
      end
    end
    check({name, "_zones_off"}, 64'(mism), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, checks so far %0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] sat_exp;
    int cnt, sent;

    rst_n = 1'b0; frame_start = 1'b0; frame_end = 1'b0; ext_rd_addr = '0;
    pix.pix_valid = 1'b0; pix.pix_zone = '0; pix.pix_g = '0;
    bd_en = 1'b0; bd_addr = '0; bd_data = '0;

    set_vec(0, 3, 7'd5, 7'd5, 7'd5, 7'd0, 8'd10, 8'd20, 8'd30, 8'd0,
            7'd5, 7'd4, 7'd6, 60'd60, 60'd0, 60'd0);
    set_vec(1, 4, 7'd3, 7'd4, 7'd3, 7'd4, 8'd1, 8'd2, 8'd3, 8'd4,
            7'd3, 7'd4, 7'd0, 60'd4, 60'd6, 60'd0);
    set_vec(2, 4, 7'd9, 7'd9, 7'd9, 7'd9, 8'd255, 8'd255, 8'd255, 8'd255,
            7'd9, 7'd8, 7'd10, 60'd1020, 60'd0, 60'd0);
    set_vec(3, 2, 7'd127, 7'd0, 7'd0, 7'd0, 8'd1, 8'd2, 8'd0, 8'd0,
            7'd127, 7'd0, 7'd1, 60'd1, 60'd2, 60'd0);

    repeat (3) @(negedge clk);
    check("rst_pix_ready", 64'(pix.pix_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_wr_en", 64'(ram_wr_en), 64'd0);
    check("rst_wr_addr", 64'(ram_wr_addr), 64'd0);
    check("rst_wr_data", 64'(ram_wr_data), 64'd0);
    check("rst_rd_addr", 64'(ram_rd_addr), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    @(negedge clk);
    check("idle_frame_end_busy", 64'(busy), 64'd0);
    check("idle_frame_end_done", 64'(frame_done), 64'd0);

    for (int v = 0; v < 4; v++) begin
      start_and_clear($sformatf("vec%0d", v), 1'b0);
      for (int i = 0; i < int'(vecs[v].n); i++)
        send(vecs[v].zone[i], vecs[v].g[i], i == int'(vecs[v].n) - 1);
      finish_frame($sformatf("vec%0d", v));
      for (int j = 0; j < 3; j++) begin
        readback(vecs[v].cz[j], d);
        check($sformatf("vec%0d_zone%0d", v, vecs[v].cz[j]), 64'(d), 64'(vecs[v].ce[j]));
      end
      compare_all($sformatf("vec%0d", v));
    end

    // Pixel held valid through the clear sweep is only taken once ACCUM starts.
    pix.pix_valid = 1'b1; pix.pix_zone = 7'd127; pix.pix_g = 8'd255;
    start_and_clear("hold", 1'b0);
    send(7'd127, 8'd255, 1'b1);
    finish_frame("hold");
    readback(7'd127, d);
    check("hold_zone127", 64'(d), 64'd255);
    compare_all("hold");

    // Abort mid-ACCUM with frame_end in the same cycle: frame_start wins.
    start_and_clear("abort_pre", 1'b0);
    send(7'd20, 8'd50, 1'b0);
    send(7'd20, 8'd60, 1'b0);
    start_and_clear("abort", 1'b1);
    send(7'd20, 8'd7, 1'b1);
    finish_frame("abort");
    readback(7'd20, d);
    check("abort_zone20", 64'(d), 64'd7);
    compare_all("abort");

    // Near-full zone 0 via backdoor, then one pixel; also checks the 2-edge write latency.
    start_and_clear("sat", 1'b0);
    bd_en = 1'b1; bd_addr = '0; bd_data = MAX_SUM - 60'd4;
    @(negedge clk);
    bd_en = 1'b0;
    model[0] = MAX_SUM - 60'd4;
`ifdef ZONE_ACC_SAT_EN
    sat_exp = MAX_SUM;
`else
    sat_exp = 60'd5;
`endif
    pix.pix_valid = 1'b1; pix.pix_zone = '0; pix.pix_g = 8'd10; frame_end = 1'b1;
    model[0] = ref_add(model[0], 8'd10);
    @(negedge clk);
    pix.pix_valid = 1'b0; frame_end = 1'b0;
    check("lat_wr_en_after_s1", 64'(ram_wr_en), 64'd0);
    @(negedge clk);
    check("lat_wr_en_after_s2", 64'(ram_wr_en), 64'd1);
    check("lat_wr_addr", 64'(ram_wr_addr), 64'd0);
    check("lat_wr_data", 64'(ram_wr_data), 64'(sat_exp));
    finish_frame("sat");
    readback('0, d);
    check("sat_zone0", 64'(d), 64'(sat_exp));
    compare_all("sat");

    for (int f = 0; f < 6; f++) begin
      start_and_clear($sformatf("rand%0d", f), 1'b0);
      cnt  = int'($urandom_range(5, 40));
      sent = 0;
      while (sent < cnt) begin
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
        end else begin
          send(ADDR_W'($urandom_range(0, 7)), PIX_W'($urandom), sent == cnt - 1);
          sent++;
        end
      end
      finish_frame($sformatf("rand%0d", f));
      compare_all($sformatf("rand%0d", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
